// File: rtl/periph_led_pwm_if.sv
// Register-bus handshake for the LED PWM peripheral: address, strobes and acknowledge.
// The tristate data lines stay a plain inout port on the peripheral.
interface periph_led_pwm_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] addr;
   logic                  read;
   logic                  write;
   logic                  ready;

   modport master (output addr, output read, output write, input ready);
   modport slave  (input addr, input read, input write, output ready);
endinterface

// File: rtl/periph_led_pwm.sv
// Multi-channel LED PWM peripheral with a shared prescaler, a global enable and per-channel blink gating.
// Standard peripheral header registers sit at addresses 0-3, followed by the blink mask and the duty registers.
`ifndef PERIPH_DATA_WIDTH
`define PERIPH_DATA_WIDTH 32
`endif
`ifndef PERIPH_ADDR_WIDTH
`define PERIPH_ADDR_WIDTH 8
`endif

module periph_led_pwm #(
   parameter int DATA_WIDTH     = `PERIPH_DATA_WIDTH,
   parameter int ADDR_WIDTH     = `PERIPH_ADDR_WIDTH,
   parameter int CHANNELS       = 8,
   parameter int PWM_BITS       = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   periph_led_pwm_if.slave       bus,
   inout  wire  [DATA_WIDTH-1:0] data,
   output logic [CHANNELS-1:0]   out
);
   localparam logic [DATA_WIDTH-1:0] CLASS_ID = DATA_WIDTH'(32'h0000_0002);
   localparam logic [DATA_WIDTH-1:0] PID_VID  = DATA_WIDTH'(32'h0001_0001);

   logic                      en_q, en_d;
   logic [7:0]                blink_div_q, blink_div_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic [CHANNELS-1:0]       blink_mask_q, blink_mask_d;
   logic [PWM_BITS:0]         duty_q [CHANNELS];
   logic [PWM_BITS:0]         duty_d [CHANNELS];

   logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
   logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
   logic [7:0]                blink_cnt_q, blink_cnt_d;
   logic                      blink_phase_q, blink_phase_d;
   logic [CHANNELS-1:0]       out_q, out_d;
   logic                      ready_q, ready_d;

   logic                      wr_cfg;
   logic                      tick;
   logic                      period_end;
   logic [DATA_WIDTH-1:0]     rdata;
   logic                      unused_data;

   // Only part of the bus word lands in registers; fold the rest away.
   assign unused_data = ^data;

   always_comb begin
      en_d         = en_q;
      blink_div_d  = blink_div_q;
      prescale_d   = prescale_q;
      blink_mask_d = blink_mask_q;
      duty_d       = duty_q;
      wr_cfg       = 1'b0;
      if (bus.write) begin
         if (bus.addr == ADDR_WIDTH'(2)) begin
            wr_cfg      = 1'b1;
            en_d        = data[31];
            blink_div_d = data[23:16];
            prescale_d  = data[PRESCALE_WIDTH-1:0];
         end
         if (bus.addr == ADDR_WIDTH'(4)) begin
            blink_mask_d = data[CHANNELS-1:0];
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (bus.addr == ADDR_WIDTH'(5 + i)) begin
               duty_d[i] = data[PWM_BITS:0];
            end
         end
      end
   end

   // Counters are pinned to zero while disabled so enabling always starts a fresh period.
   always_comb begin
      tick          = en_q && (presc_cnt_q == prescale_q);
      period_end    = tick && (pwm_cnt_q == '1);
      presc_cnt_d   = '0;
      pwm_cnt_d     = '0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      if (en_q) begin
         presc_cnt_d   = (wr_cfg || tick) ? '0 : presc_cnt_q + PRESCALE_WIDTH'(1);
         pwm_cnt_d     = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
         blink_cnt_d   = blink_cnt_q;
         blink_phase_d = blink_phase_q;
         if (period_end) begin
            if (blink_cnt_q == blink_div_q) begin
               blink_cnt_d   = '0;
               blink_phase_d = ~blink_phase_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 8'd1;
            end
         end
      end
      for (int i = 0; i < CHANNELS; i++) begin
         out_d[i] = en_q && ({1'b0, pwm_cnt_q} < duty_q[i]) && (!blink_mask_q[i] || blink_phase_q);
      end
      ready_d = bus.read || bus.write;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q          <= 1'b0;
         blink_div_q   <= '0;
         prescale_q    <= '0;
         blink_mask_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            duty_q[i] <= '0;
         end
         presc_cnt_q   <= '0;
         pwm_cnt_q     <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         out_q         <= '0;
         ready_q       <= 1'b0;
      end else begin
         en_q          <= en_d;
         blink_div_q   <= blink_div_d;
         prescale_q    <= prescale_d;
         blink_mask_q  <= blink_mask_d;
         for (int i = 0; i < CHANNELS; i++) begin
            duty_q[i] <= duty_d[i];
         end
         presc_cnt_q   <= presc_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         out_q         <= out_d;
         ready_q       <= ready_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.addr == ADDR_WIDTH'(0)) begin
         rdata = CLASS_ID;
      end else if (bus.addr == ADDR_WIDTH'(1)) begin
         rdata = PID_VID;
      end else if (bus.addr == ADDR_WIDTH'(2)) begin
         rdata[31]                   = en_q;
         rdata[23:16]                = blink_div_q;
         rdata[PRESCALE_WIDTH-1:0]   = prescale_q;
      end else if (bus.addr == ADDR_WIDTH'(3)) begin
         rdata[CHANNELS-1:0] = out_q;
         rdata[31]           = en_q;
         rdata[30]           = blink_phase_q;
      end else if (bus.addr == ADDR_WIDTH'(4)) begin
         rdata[CHANNELS-1:0] = blink_mask_q;
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.addr == ADDR_WIDTH'(5 + i)) begin
            rdata[PWM_BITS:0] = duty_q[i];
         end
      end
   end

   // A write wins over a simultaneous read, so the bus is left to the writer.
   assign data      = (bus.read && !bus.write) ? rdata : 'z;
   assign bus.ready = ready_q;
   assign out       = out_q;

endmodule

// File: tb/tb_periph_led_pwm.sv
// Self-checking bench for periph_led_pwm: register tables through a read scoreboard,
// plus windowed PWM/prescaler/blink checks against a closed-form output model.
module tb_periph_led_pwm;
   logic        clk;
   logic        rst;
   wire  [31:0] data_w;
   logic [31:0] tb_dout;
   logic        tb_oe;
   logic [7:0]  out_w;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] exp;
      logic [31:0] mask;
      string       name;
   } rd_vec_t;

   typedef struct {
      logic [31:0] exp;
      logic [31:0] mask;
      string       name;
   } sb_t;

   sb_t     sb_q[$];
   rd_vec_t t_reset[7];
   rd_vec_t t_rw[6];
   rd_vec_t t_edge[4];

   periph_led_pwm_if #(.ADDR_WIDTH(8)) bus();

   periph_led_pwm dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .data (data_w),
      .out  (out_w)
   );

   assign data_w = tb_oe ? tb_dout : 'z;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk_released(input string nm);
      n_checks++;
      if (!((data_w === {32{1'bz}}) || (data_w == 32'h0))) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h required high-Z", nm, data_w);
      end
   endtask

   function automatic logic model_out(input int k, input int presc, input int bd,
                                      input int duty, input logic masked);
      int   n;
      int   pwm;
      int   periods;
      logic phase;
      if (k < 1) return 1'b0;
      n       = (k - 1) / (presc + 1);
      pwm     = n % 256;
      periods = n / 256;
      phase   = ((periods / (bd + 1)) % 2) == 1;
      return (pwm < duty) && (!masked || phase);
   endfunction

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic with_read);
      @(posedge clk); #1;
      bus.addr  = a;
      tb_dout   = d;
      tb_oe     = 1'b1;
      bus.write = 1'b1;
      bus.read  = with_read;
      if (with_read) begin
         @(negedge clk);
         chk("rw_data_not_driven_by_dut", data_w, d);
      end
      @(posedge clk); #1;
      bus.write = 1'b0;
      bus.read  = 1'b0;
      tb_oe     = 1'b0;
      if (with_read) begin
         @(negedge clk);
         chk("rw_ready", {31'b0, bus.ready}, 32'h1);
      end
   endtask

   task automatic do_read(input logic [7:0] a, input logic [31:0] e, input logic [31:0] m,
                          input string nm);
      sb_t         s;
      sb_t         got;
      logic [31:0] cap;
      @(posedge clk); #1;
      bus.addr = a;
      bus.read = 1'b1;
      s.exp    = e;
      s.mask   = m;
      s.name   = nm;
      sb_q.push_back(s);
      @(negedge clk);
      cap = data_w;
      @(posedge clk); #1;
      bus.read = 1'b0;
      @(negedge clk);
      chk({nm, "_ready"}, {31'b0, bus.ready}, 32'h1);
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_scoreboard: got empty queue required one entry", nm);
      end else begin
         got = sb_q.pop_front();
         chk(got.name, cap & got.mask, got.exp);
      end
      chk_released({nm, "_release"});
   endtask

   task automatic run_window(input string nm, input int n, input int presc, input int bd,
                             input int d0, input int d1, input int d2, input logic [2:0] msk,
                             input int h0, input int h1, input int h2);
      int hi[3];
      int bad[3];
      int duty[3];
      int hexp[3];
      hi   = '{0, 0, 0};
      bad  = '{0, 0, 0};
      duty = '{d0, d1, d2};
      hexp = '{h0, h1, h2};
      @(negedge clk);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            logic e;
            e = model_out(k, presc, bd, duty[c], msk[c]);
            if (out_w[c] === 1'b1) hi[c]++;
            if (out_w[c] !== e) bad[c]++;
         end
      end
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("%s_ch%0d_high_cycles", nm, c), hi[c], hexp[c]);
         chk($sformatf("%s_ch%0d_pattern_errors", nm, c), bad[c], 0);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      tb_oe     = 1'b0;
      tb_dout   = '0;
      bus.addr  = '0;
      bus.read  = 1'b0;
      bus.write = 1'b0;

      t_reset[0] = '{8'd0,   32'h0000_0002, 32'hFFFF_FFFF, "rd_class"};
      t_reset[1] = '{8'd1,   32'h0001_0001, 32'hFFFF_FFFF, "rd_pid_vid"};
      t_reset[2] = '{8'd2,   32'h0000_0000, 32'hFFFF_FFFF, "rd_config_rst"};
      t_reset[3] = '{8'd3,   32'h0000_0000, 32'hFFFF_FFFF, "rd_status_rst"};
      t_reset[4] = '{8'd4,   32'h0000_0000, 32'hFFFF_FFFF, "rd_mask_rst"};
      t_reset[5] = '{8'd5,   32'h0000_0000, 32'hFFFF_FFFF, "rd_duty0_rst"};
      t_reset[6] = '{8'd13,  32'h0000_0000, 32'hFFFF_FFFF, "rd_unmapped13"};

      t_rw[0] = '{8'd2,  32'h80FF_FFFF, 32'hFFFF_FFFF, "rd_config_bits"};
      t_rw[1] = '{8'd4,  32'h0000_00FF, 32'hFFFF_FFFF, "rd_mask_bits"};
      t_rw[2] = '{8'd5,  32'h0000_01FF, 32'hFFFF_FFFF, "rd_duty0_bits"};
      t_rw[3] = '{8'd12, 32'h0000_0034, 32'hFFFF_FFFF, "rd_duty7_bits"};
      t_rw[4] = '{8'd13, 32'h0000_0000, 32'hFFFF_FFFF, "rd_past_last_duty"};
      t_rw[5] = '{8'd3,  32'h8000_0000, 32'h8000_0000, "rd_status_en"};

      t_edge[0] = '{8'd0,   32'h0000_0002, 32'hFFFF_FFFF, "rd_class_after_wr"};
      t_edge[1] = '{8'd1,   32'h0001_0001, 32'hFFFF_FFFF, "rd_pid_after_wr"};
      t_edge[2] = '{8'd200, 32'h0000_0000, 32'hFFFF_FFFF, "rd_addr200_after_wr"};
      t_edge[3] = '{8'd8,   32'h0000_0009, 32'hFFFF_FFFF, "rd_duty3_after_rw"};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out", {24'b0, out_w}, 32'h0);
      chk("reset_ready", {31'b0, bus.ready}, 32'h0);
      chk_released("reset_data_z");
      rst = 1'b0;

      foreach (t_reset[i]) do_read(t_reset[i].addr, t_reset[i].exp, t_reset[i].mask, t_reset[i].name);

      do_write(8'd2,  32'hFFFF_FFFF, 1'b0);
      do_write(8'd4,  32'hFFFF_FFFF, 1'b0);
      do_write(8'd5,  32'hFFFF_FFFF, 1'b0);
      do_write(8'd12, 32'h0000_1234, 1'b0);
      foreach (t_rw[i]) do_read(t_rw[i].addr, t_rw[i].exp, t_rw[i].mask, t_rw[i].name);

      do_write(8'd8,   32'h0000_0009, 1'b1);
      do_write(8'd0,   32'hDEAD_BEEF, 1'b0);
      do_write(8'd200, 32'h1234_5678, 1'b0);
      foreach (t_edge[i]) do_read(t_edge[i].addr, t_edge[i].exp, t_edge[i].mask, t_edge[i].name);

      do_write(8'd2, 32'h0000_0000, 1'b0);
      do_write(8'd4, 32'h0000_0000, 1'b0);
      do_write(8'd5, 32'd64, 1'b0);
      do_write(8'd6, 32'd0, 1'b0);
      do_write(8'd7, 32'd256, 1'b0);
      do_write(8'd2, 32'h8000_0000, 1'b0);
      run_window("duty", 256, 0, 0, 64, 0, 256, 3'b000, 64, 0, 256);

      @(negedge clk);
      chk("out2_on_before_disable", {31'b0, out_w[2]}, 32'h1);
      do_write(8'd2, 32'h0000_0000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("out_off_after_disable", {24'b0, out_w}, 32'h0);
      do_read(8'd3, 32'h0000_0000, 32'hFFFF_FFFF, "rd_status_disabled");
      do_write(8'd2, 32'h8000_0000, 1'b0);
      run_window("restart", 256, 0, 0, 64, 0, 256, 3'b000, 64, 0, 256);

      do_write(8'd2, 32'h0000_0000, 1'b0);
      do_write(8'd5, 32'd128, 1'b0);
      do_write(8'd2, 32'h8000_0003, 1'b0);
      run_window("prescale", 1024, 3, 0, 128, 0, 256, 3'b000, 512, 0, 1024);

      do_write(8'd2, 32'h0000_0000, 1'b0);
      do_write(8'd4, 32'h0000_0001, 1'b0);
      do_write(8'd5, 32'd256, 1'b0);
      do_write(8'd2, 32'h8001_0000, 1'b0);
      run_window("blink", 1024, 0, 1, 256, 0, 256, 3'b001, 512, 0, 1024);
      repeat (776) @(negedge clk);
      do_read(8'd3, 32'hC000_0000, 32'hC000_0000, "rd_status_phase1");
      repeat (400) @(negedge clk);
      do_read(8'd3, 32'h8000_0000, 32'hC000_0000, "rd_status_phase0");

      @(posedge clk); #1;
      bus.addr = 8'd1;
      bus.read = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_ready", {31'b0, bus.ready}, 32'h1);
      chk("pre_reset_out2", {31'b0, out_w[2]}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_out", {24'b0, out_w}, 32'h0);
      chk("async_reset_ready", {31'b0, bus.ready}, 32'h0);
      bus.read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_read(8'd2, 32'h0000_0000, 32'hFFFF_FFFF, "rd_config_after_reset");
      do_read(8'd7, 32'h0000_0000, 32'hFFFF_FFFF, "rd_duty2_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
